axi_dmem_bridge: RTL and testbench
==================================

AXI_DMEM_BRIDGE -- requirements
Module: axi_dmem_bridge

Interface
REQ-001 SHALL have parameter WIDTH, 32, data bits per memory word and AXI data width.
REQ-002 SHALL have parameter SIZE, 256, memory depth in words; LOGSIZE=$clog2(SIZE) local.
REQ-003 clk  in  1  clock for all logic and the memory B port.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 s_awaddr  in  32  AXI4-Lite write byte address.
REQ-006 s_awvalid / s_awready  in / out  1  write-address handshake.
REQ-007 s_wdata  in  WIDTH  write data.
REQ-008 s_wstrb  in  WIDTH/8  byte strobes.
REQ-009 s_wvalid / s_wready  in / out  1  write-data handshake.
REQ-010 s_bresp  out  2  write response.
REQ-011 s_bvalid / s_bready  out / in  1  write-response handshake.
REQ-012 s_araddr  in  32  read byte address.
REQ-013 s_arvalid / s_arready  in / out  1  read-address handshake.
REQ-014 s_rdata  out  WIDTH  read data, registered.
REQ-015 s_rresp  out  2  read response.
REQ-016 s_rvalid / s_rready  out / in  1  read-data handshake.
REQ-017 mem_byte_addr  out  LOGSIZE+2  byte address to memory port B.
REQ-018 mem_wdata  out  WIDTH  write data to memory port B.
REQ-019 mem_byte_wr_en  out  WIDTH/8  byte write enables to memory port B.
REQ-020 mem_rdata  in  WIDTH  memory port B read data, valid one clk after mem_byte_addr is presented.

Function
REQ-021 FSM states SHALL be IDLE, WR, WRESP, RD_ADDR, RD_CAPT, RRESP; one transaction in flight at a time.
REQ-022 In IDLE, AW and W SHALL be accepted independently (any order/cycle), each latched once; s_awready/s_wready low once its beat is held.
REQ-023 Cycle after both AW and W are held: state WR, mem_byte_wr_en=latched wstrb for exactly one cycle; next cycle WRESP, s_bvalid=1 until s_bready.
REQ-024 mem_byte_wr_en SHALL be zero in every state except WR.
REQ-025 Read: AR handshake at cycle T; T+1 RD_ADDR presents address; T+2 RD_CAPT registers mem_rdata into s_rdata; T+3 RRESP, s_rvalid=1 until s_rready.
REQ-026 s_arready SHALL be high only in IDLE with no AW/W beat held and read granted.
REQ-027 Arbitration: if arvalid and (awvalid or wvalid) in IDLE with nothing held, grant goes opposite to last completed transaction type (round-robin); after reset write wins.
REQ-028 Address bits [1:0] SHALL be ignored; mem_byte_addr[1:0]=0; mem_byte_addr holds last value outside active states.
REQ-029 s_rdata, s_bresp, s_rresp SHALL stay stable while the corresponding valid is high and ready low.
REQ-030 Return to IDLE on the cycle after the final B/R handshake; a new request SHALL be accepted no earlier than that IDLE cycle.

Reset
REQ-031 On reset: state IDLE, all ready/valid outputs 0, s_rdata/resp/mem_* outputs 0, held beats discarded, round-robin to write; a reset during WR SHALL suppress mem_byte_wr_en that cycle.

Configuration
REQ-032 With DMEM_AXI_RANGE_CHECK_EN defined, address >= SIZE*4 SHALL return SLVERR (2'b10), perform no write (mem_byte_wr_en stays 0), s_rdata=0, same latency.
REQ-033 Without DMEM_AXI_RANGE_CHECK_EN, upper address bits SHALL be dropped (wrap modulo SIZE*4) and all responses OKAY (2'b00).

Structure
REQ-034 Package dmem_axi_pkg SHALL hold the FSM state enum and RESP_OKAY/RESP_SLVERR constants.
REQ-035 Single module, no sub-module; connects directly to the data memory port B with clk tied to its port-B clock.

Verification
REQ-036 AW 0x10 and W 0xDEADBEEF strb 0xF same cycle -> WR one cycle later with mem_byte_addr 0x10, wr_en 0xF; bvalid two cycles after handshake, bresp 0.
REQ-037 W strb 0x4 three cycles before AW 0x08 -> one write, wr_en 0x4 only, no wr_en during wait.
REQ-038 AR 0x10 after write above -> rvalid 3 cycles after AR handshake, rdata 0xDEADBEEF; rready held low 5 cycles -> rdata stable.
REQ-039 AR and AW+W valid together twice in a row -> write, then read, then write order; ready never high for both types at once.
REQ-040 Address 0x400 (SIZE 256): with macro -> SLVERR, no wr_en, rdata 0; without -> access word 0, OKAY.
REQ-041 Reset asserted during WR and during RRESP -> wr_en 0, bvalid/rvalid drop next cycle, state IDLE, memory word unchanged.

Source files
------------

// File: rtl/dmem_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_axi_pkg
// Description : Shared types and constants for the AXI4-Lite to data-memory
//               bridge: FSM state encoding and AXI response codes.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_axi_pkg;

    // One transaction in flight; writes pass through WR/WRESP and reads
    // through RD_ADDR/RD_CAPT/RRESP before returning to IDLE.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WRESP   = 3'd2,
        RD_ADDR = 3'd3,
        RD_CAPT = 3'd4,
        RRESP   = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage : dmem_axi_pkg
`default_nettype wire

// File: rtl/axi_dmem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_dmem_bridge_if
// Description : AXI4-Lite bus bundle between a master and the data-memory
//               bridge. The slave modport is used by axi_dmem_bridge, the
//               master modport by whatever drives the bus.
// Signals     : AW  s_awaddr/s_awvalid/s_awready
//               W   s_wdata/s_wstrb/s_wvalid/s_wready
//               B   s_bresp/s_bvalid/s_bready
//               AR  s_araddr/s_arvalid/s_arready
//               R   s_rdata/s_rresp/s_rvalid/s_rready
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_dmem_bridge_if #(
    parameter int WIDTH = 32
) ();
    logic [31:0]        s_awaddr;
    logic               s_awvalid;
    logic               s_awready;
    logic [WIDTH-1:0]   s_wdata;
    logic [WIDTH/8-1:0] s_wstrb;
    logic               s_wvalid;
    logic               s_wready;
    logic [1:0]         s_bresp;
    logic               s_bvalid;
    logic               s_bready;
    logic [31:0]        s_araddr;
    logic               s_arvalid;
    logic               s_arready;
    logic [WIDTH-1:0]   s_rdata;
    logic [1:0]         s_rresp;
    logic               s_rvalid;
    logic               s_rready;

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid, s_arready,
               s_rdata, s_rresp, s_rvalid
    );

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid, s_arready,
               s_rdata, s_rresp, s_rvalid
    );
endinterface : axi_dmem_bridge_if
`default_nettype wire

// File: rtl/axi_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : axi_dmem_bridge
// Description : AXI4-Lite slave that drives port B of a synchronous data
//               memory (read data one clk after the address). One
//               transaction at a time; reads and writes competing in IDLE
//               are arbitrated round-robin, write first after reset.
// Ports       : clk, reset       - clock (also memory port-B clock), sync
//                                  active-high reset
//               s_axi            - AXI4-Lite slave bundle
//               mem_byte_addr    - word-aligned byte address to port B
//               mem_wdata        - write data to port B
//               mem_byte_wr_en   - byte write enables to port B
//               mem_rdata        - port-B read data
// Options     : DMEM_AXI_RANGE_CHECK_EN - addresses >= SIZE*4 get SLVERR,
//               no write and zero read data; otherwise addresses wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_dmem_bridge
    import dmem_axi_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int SIZE    = 256,
    localparam int LOGSIZE = $clog2(SIZE)
) (
    input  wire                   clk,
    input  wire                   reset,
    axi_dmem_bridge_if.slave      s_axi,
    output logic [LOGSIZE+1:0]    mem_byte_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic [WIDTH/8-1:0]    mem_byte_wr_en,
    input  wire  [WIDTH-1:0]      mem_rdata
);

    state_t               r_state;
    state_t               w_next;

    logic                 r_aw_held;
    logic                 r_w_held;
    logic                 r_last_wr;   // last completed transaction was a write
    logic                 r_wr_err;
    logic                 r_rd_err;
    logic [LOGSIZE+1:0]   r_awaddr;
    logic [LOGSIZE+1:0]   r_mem_addr;
    logic [WIDTH-1:0]     r_wdata;
    logic [WIDTH/8-1:0]   r_wstrb;
    logic [WIDTH-1:0]     r_rdata;
    logic [1:0]           r_bresp;
    logic [1:0]           r_rresp;

    logic                 w_rd_grant;
    logic                 w_aw_hs;
    logic                 w_w_hs;
    logic                 w_wr_go;
    logic                 w_aw_err;
    logic                 w_ar_err;
    logic                 w_unused_addr_bits;

`ifdef DMEM_AXI_RANGE_CHECK_EN
    assign w_aw_err = |s_axi.s_awaddr[31:LOGSIZE+2];
    assign w_ar_err = |s_axi.s_araddr[31:LOGSIZE+2];
    assign w_unused_addr_bits = ^{s_axi.s_awaddr[1:0], s_axi.s_araddr[1:0]};
`else
    assign w_aw_err = 1'b0;
    assign w_ar_err = 1'b0;
    assign w_unused_addr_bits = ^{s_axi.s_awaddr[31:LOGSIZE+2], s_axi.s_awaddr[1:0],
                                  s_axi.s_araddr[31:LOGSIZE+2], s_axi.s_araddr[1:0]};
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Everything is forced quiet while reset is high so that a reset landing
    // on the WR cycle never reaches the memory.
    always_comb begin
        w_next            = r_state;
        w_rd_grant        = 1'b0;
        w_aw_hs           = 1'b0;
        w_w_hs            = 1'b0;
        w_wr_go           = 1'b0;
        s_axi.s_awready   = 1'b0;
        s_axi.s_wready    = 1'b0;
        s_axi.s_arready   = 1'b0;
        s_axi.s_bvalid    = 1'b0;
        s_axi.s_rvalid    = 1'b0;
        mem_byte_wr_en    = '0;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    // A read only starts from a clean IDLE; when both kinds
                    // are pending the one not served last time wins.
                    w_rd_grant = !r_aw_held && !r_w_held && s_axi.s_arvalid &&
                                 (!(s_axi.s_awvalid || s_axi.s_wvalid) || r_last_wr);
                    s_axi.s_arready = w_rd_grant;
                    s_axi.s_awready = !r_aw_held && !w_rd_grant;
                    s_axi.s_wready  = !r_w_held  && !w_rd_grant;
                    w_aw_hs = s_axi.s_awvalid && !r_aw_held && !w_rd_grant;
                    w_w_hs  = s_axi.s_wvalid  && !r_w_held  && !w_rd_grant;
                    w_wr_go = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
                    if (w_wr_go)         w_next = WR;
                    else if (w_rd_grant) w_next = RD_ADDR;
                end
                WR: begin
                    if (!r_wr_err) mem_byte_wr_en = r_wstrb;
                    w_next = WRESP;
                end
                WRESP: begin
                    s_axi.s_bvalid = 1'b1;
                    if (s_axi.s_bready) w_next = IDLE;
                end
                RD_ADDR: w_next = RD_CAPT;
                RD_CAPT: w_next = RRESP;
                RRESP: begin
                    s_axi.s_rvalid = 1'b1;
                    if (s_axi.s_rready) w_next = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_last_wr  <= 1'b0;
            r_wr_err   <= 1'b0;
            r_rd_err   <= 1'b0;
            r_awaddr   <= '0;
            r_mem_addr <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_rdata    <= '0;
            r_bresp    <= RESP_OKAY;
            r_rresp    <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= {s_axi.s_awaddr[LOGSIZE+1:2], 2'b00};
                r_wr_err  <= w_aw_err;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axi.s_wdata;
                r_wstrb  <= s_axi.s_wstrb;
            end
            // Entering WR: the address may arrive on this very cycle.
            if (w_wr_go) begin
                r_aw_held  <= 1'b0;
                r_w_held   <= 1'b0;
                r_mem_addr <= w_aw_hs ? {s_axi.s_awaddr[LOGSIZE+1:2], 2'b00} : r_awaddr;
            end
            if (w_rd_grant) begin
                r_mem_addr <= {s_axi.s_araddr[LOGSIZE+1:2], 2'b00};
                r_rd_err   <= w_ar_err;
            end
            if (r_state == WR)
                r_bresp <= r_wr_err ? RESP_SLVERR : RESP_OKAY;
            if (r_state == RD_CAPT) begin
                r_rdata <= r_rd_err ? '0 : mem_rdata;
                r_rresp <= r_rd_err ? RESP_SLVERR : RESP_OKAY;
            end
            if (r_state == WRESP && s_axi.s_bready) r_last_wr <= 1'b1;
            if (r_state == RRESP && s_axi.s_rready) r_last_wr <= 1'b0;
        end
    end

    assign s_axi.s_bresp = r_bresp;
    assign s_axi.s_rresp = r_rresp;
    assign s_axi.s_rdata = r_rdata;
    assign mem_byte_addr = r_mem_addr;
    assign mem_wdata     = r_wdata;

endmodule : axi_dmem_bridge
`default_nettype wire

// File: tb/tb_axi_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_dmem_bridge
// Description : Self-checking bench for axi_dmem_bridge. Provides the port-B
//               memory, a word-array reference model, a table of directed
//               transactions, hand-written arbitration/reset sequences and
//               randomized traffic. Follows DMEM_AXI_RANGE_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_dmem_bridge;
    import dmem_axi_pkg::*;

    localparam int WIDTH   = 32;
    localparam int SIZE    = 256;
    localparam int LOGSIZE = 8;
`ifdef DMEM_AXI_RANGE_CHECK_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi_dmem_bridge_if #(.WIDTH(WIDTH)) bus ();
    logic [LOGSIZE+1:0] mem_byte_addr;
    logic [WIDTH-1:0]   mem_wdata;
    logic [WIDTH/8-1:0] mem_byte_wr_en;
    logic [WIDTH-1:0]   mem_rdata;

    axi_dmem_bridge #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk            (clk),
        .reset          (reset),
        .s_axi          (bus),
        .mem_byte_addr  (mem_byte_addr),
        .mem_wdata      (mem_wdata),
        .mem_byte_wr_en (mem_byte_wr_en),
        .mem_rdata      (mem_rdata)
    );

    // Port-B memory: synchronous read, byte-enabled write.
    logic [31:0] mem [SIZE];
    logic        mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < SIZE; i++) mem[i] <= '0;
            mem_init_done <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_byte_wr_en[b])
                    mem[mem_byte_addr[LOGSIZE+1:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        mem_rdata <= mem[mem_byte_addr[LOGSIZE+1:2]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor, sampled well after the falling edge.
    int          wr_count = 0;
    int          wr_cyc   = 0;
    logic [3:0]  wr_last_en = '0;
    logic [9:0]  wr_last_addr = '0;
    int          both_rdy = 0;
    int          lsb_bad  = 0;
    always @(negedge clk) begin
        #2;
        if (mem_byte_wr_en != 0) begin
            wr_count++;
            wr_cyc       = cyc;
            wr_last_en   = mem_byte_wr_en;
            wr_last_addr = mem_byte_addr;
        end
        if (bus.s_arready && (bus.s_awready || bus.s_wready)) both_rdy++;
        if (mem_byte_addr[1:0] != 2'b00) lsb_bad++;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [SIZE];

    function automatic bit in_range(input logic [31:0] a);
`ifdef DMEM_AXI_RANGE_CHECK_EN
        return a < SIZE * 4;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % SIZE);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // ---------------- bus tasks ----------------
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_at, input int w_at,
                             input int b_dly, input logic [1:0] exp_resp);
        int k; int h; int wc0; bit aw_done; bit w_done; bit ok; bit stable;
        k = 0; h = 0; wc0 = wr_count; aw_done = 0; w_done = 0; ok = 0; stable = 1;
        while (!(aw_done && w_done) && k < 40) begin
            @(negedge clk);
            bus.s_awaddr  = addr;
            bus.s_wdata   = data;
            bus.s_wstrb   = strb;
            bus.s_awvalid = !aw_done && (k >= aw_at);
            bus.s_wvalid  = !w_done && (k >= w_at);
            #1;
            if (bus.s_awvalid && bus.s_awready) begin aw_done = 1; h = cyc; end
            if (bus.s_wvalid && bus.s_wready)   begin w_done = 1;  h = cyc; end
            k++;
        end
        chk("aw_w_accept", 32'(aw_done && w_done), 32'd1);
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            bus.s_awvalid = 0;
            bus.s_wvalid  = 0;
            #1;
            if (bus.s_bvalid) begin ok = 1; break; end
            k++;
        end
        chk("b_latency", ok ? 32'(cyc - h) : 32'hFFFF_FFFF, 32'd2);
        chk("bresp", 32'(bus.s_bresp), 32'(exp_resp));
        chk("wr_pulses", 32'(wr_count - wc0), in_range(addr) ? 32'd1 : 32'd0);
        if (in_range(addr)) begin
            chk("wr_en", 32'(wr_last_en), 32'(strb));
            chk("wr_addr", 32'(wr_last_addr), {22'd0, addr[9:2], 2'b00});
            chk("wr_cycle", 32'(wr_cyc), 32'(h + 1));
            ref_mem[widx(addr)] = merge(ref_mem[widx(addr)], data, strb);
        end
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk); #1;
            if (!bus.s_bvalid || bus.s_bresp !== exp_resp) stable = 0;
        end
        chk("b_stable", 32'(stable), 32'd1);
        @(negedge clk); bus.s_bready = 1;
        @(negedge clk); bus.s_bready = 0; #1;
        chk("b_done", 32'(bus.s_bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int r_dly, input logic [1:0] exp_resp);
        int k; int h; bit done; bit ok; bit stable; logic [31:0] exp_data;
        k = 0; h = 0; done = 0; ok = 0; stable = 1;
        exp_data = in_range(addr) ? ref_mem[widx(addr)] : 32'h0;
        while (!done && k < 40) begin
            @(negedge clk);
            bus.s_araddr  = addr;
            bus.s_arvalid = 1;
            #1;
            if (bus.s_arready) begin done = 1; h = cyc; end
            k++;
        end
        chk("ar_accept", 32'(done), 32'd1);
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            bus.s_arvalid = 0;
            #1;
            if (bus.s_rvalid) begin ok = 1; break; end
            k++;
        end
        chk("r_latency", ok ? 32'(cyc - h) : 32'hFFFF_FFFF, 32'd3);
        chk("rdata", bus.s_rdata, exp_data);
        chk("rresp", 32'(bus.s_rresp), 32'(exp_resp));
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk); #1;
            if (!bus.s_rvalid || bus.s_rdata !== exp_data || bus.s_rresp !== exp_resp) stable = 0;
        end
        chk("r_stable", 32'(stable), 32'd1);
        @(negedge clk); bus.s_rready = 1;
        @(negedge clk); bus.s_rready = 0; #1;
        chk("r_done", 32'(bus.s_rvalid), 32'd0);
    endtask

    task automatic clear_bus();
        bus.s_awaddr = '0; bus.s_awvalid = 0; bus.s_wdata = '0; bus.s_wstrb = '0;
        bus.s_wvalid = 0; bus.s_bready = 0; bus.s_araddr = '0; bus.s_arvalid = 0;
        bus.s_rready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_bus();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_at;
        int          w_at;
        int          b_dly;
        int          r_dly;
        logic [1:0]  exp_resp;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs [NV];

    initial begin
        int grants [3];
        int ng; int nw; int wc0;
        logic [31:0] rd_seen; logic [31:0] rd_exp; logic [31:0] wd;
        logic [31:0] a; logic [31:0] d;

        vecs[0] = '{32'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 5, RESP_OKAY};
        vecs[1] = '{32'h008, 32'h11223344, 4'h4, 3, 0, 1, 0, RESP_OKAY};
        vecs[2] = '{32'h7FE, 32'hCAFEF00D, 4'h3, 0, 2, 0, 1, OOR_RESP};
        vecs[3] = '{32'h400, 32'h55AA55AA, 4'hF, 1, 1, 2, 2, OOR_RESP};
        vecs[4] = '{32'h3F1, 32'h89ABCDEF, 4'h9, 2, 0, 0, 0, RESP_OKAY};

        for (int i = 0; i < SIZE; i++) ref_mem[i] = '0;
        clear_bus();
        reset = 1;

        // Reset state, including a pending AR that must not be accepted.
        repeat (2) @(negedge clk);
        bus.s_arvalid = 1;
        #1;
        chk("rst_arready", 32'(bus.s_arready), 32'd0);
        chk("rst_awready", 32'(bus.s_awready), 32'd0);
        chk("rst_bvalid", 32'(bus.s_bvalid), 32'd0);
        chk("rst_rvalid", 32'(bus.s_rvalid), 32'd0);
        @(negedge clk);
        bus.s_arvalid = 0;
        reset = 0;
        #1;
        chk("idle_awready", 32'(bus.s_awready), 32'd1);
        chk("idle_wready", 32'(bus.s_wready), 32'd1);
        chk("idle_rdata", bus.s_rdata, 32'h0);
        chk("idle_mem_addr", 32'(mem_byte_addr), 32'h0);
        chk("idle_wr_en", 32'(mem_byte_wr_en), 32'h0);

        // Directed write + read-back pairs.
        for (int i = 0; i < NV; i++) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_at,
                      vecs[i].w_at, vecs[i].b_dly, vecs[i].exp_resp);
            axi_read(vecs[i].addr, vecs[i].r_dly, vecs[i].exp_resp);
        end
        axi_read(32'h0, 1, RESP_OKAY);

        // Arbitration: AR and AW+W held valid together from reset.
        do_reset();
        ng = 0; nw = 0; rd_seen = 'x; rd_exp = 'x;
        bus.s_bready = 1; bus.s_rready = 1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            wd = (nw == 0) ? 32'h13579BDF : 32'h2468ACE0;
            bus.s_awaddr = 32'h20; bus.s_araddr = 32'h20;
            bus.s_wstrb = 4'hF; bus.s_wdata = wd;
            bus.s_awvalid = (ng < 3); bus.s_wvalid = (ng < 3); bus.s_arvalid = (ng < 3);
            #1;
            if (bus.s_rvalid) rd_seen = bus.s_rdata;
            if (ng < 3) begin
                if (bus.s_awready && bus.s_wready) begin
                    grants[ng] = 1; ng++; nw++;
                    ref_mem[widx(32'h20)] = wd;
                end else if (bus.s_arready) begin
                    grants[ng] = 0; ng++;
                    rd_exp = ref_mem[widx(32'h20)];
                end
            end
        end
        bus.s_bready = 0; bus.s_rready = 0;
        chk("arb_count", 32'(ng), 32'd3);
        chk("arb_first_write", 32'(grants[0]), 32'd1);
        chk("arb_then_read", 32'(grants[1]), 32'd0);
        chk("arb_then_write", 32'(grants[2]), 32'd1);
        chk("arb_rdata", rd_seen, rd_exp);
        axi_read(32'h20, 0, RESP_OKAY);

        // Reset landing on the WR cycle.
        wc0 = wr_count;
        @(negedge clk);
        bus.s_awaddr = 32'h30; bus.s_wdata = 32'hFFFFFFFF; bus.s_wstrb = 4'hF;
        bus.s_awvalid = 1; bus.s_wvalid = 1;
        #1;
        chk("rstwr_accept", 32'(bus.s_awready && bus.s_wready), 32'd1);
        @(negedge clk);
        bus.s_awvalid = 0; bus.s_wvalid = 0;
        reset = 1;
        #1;
        chk("rstwr_wr_en", 32'(mem_byte_wr_en), 32'd0);
        @(negedge clk);
        reset = 0;
        #1;
        chk("rstwr_bvalid", 32'(bus.s_bvalid), 32'd0);
        chk("rstwr_idle", 32'(bus.s_awready), 32'd1);
        chk("rstwr_no_pulse", 32'(wr_count - wc0), 32'd0);
        axi_read(32'h30, 0, RESP_OKAY);

        // Reset while a read response is waiting for rready.
        @(negedge clk);
        bus.s_araddr = 32'h10; bus.s_arvalid = 1;
        #1;
        chk("rstrd_accept", 32'(bus.s_arready), 32'd1);
        repeat (3) begin @(negedge clk); bus.s_arvalid = 0; end
        #1;
        chk("rstrd_rvalid", 32'(bus.s_rvalid), 32'd1);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        #1;
        chk("rstrd_rvalid_drop", 32'(bus.s_rvalid), 32'd0);
        chk("rstrd_rdata_clr", bus.s_rdata, 32'h0);
        chk("rstrd_idle", 32'(bus.s_awready), 32'd1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            a = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) a = a + 32'h400;
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                axi_write(a, d, 4'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                          in_range(a) ? RESP_OKAY : RESP_SLVERR);
            end else begin
                axi_read(a, int'($urandom_range(0, 2)), in_range(a) ? RESP_OKAY : RESP_SLVERR);
            end
        end

        chk("never_both_ready", 32'(both_rdy), 32'd0);
        chk("addr_lsbs_zero", 32'(lsb_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_axi_dmem_bridge
`default_nettype wire
